// File: rtl/puf_pkg.sv
// Shared types and default sizing for the PUF control blocks.
package puf_pkg;

  localparam int unsigned CNT_W_DEF         = 16;
  localparam int unsigned WINDOW_CYCLES_DEF = 4096;
  localparam int unsigned SETTLE_CYCLES_DEF = 16;
  localparam int unsigned SYNC_STAGES_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_COMPARE,
    ST_DONE
  } ro_cnt_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Synchronises one free-running oscillator into clk and flags each rising edge.
module ro_edge_sync
  import puf_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;

  // sync_q[0] is the metastability-exposed flop; the MSB is the clean copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_pair_counter.sv
// Enables a ring-oscillator pair, counts their edges over a fixed window and
// emits one response bit from comparing the two counts.
module ro_pair_counter
  import puf_pkg::*;
#(
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_a_in,
  input  logic             ro_b_in,
  output logic             ro_enable,
  output logic             busy,
  output logic             resp_valid,
  output logic             resp_bit,
  output logic             tie,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  localparam int unsigned TMR_MAX = max_u(WINDOW_CYCLES, SETTLE_CYCLES);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  ro_cnt_state_t    state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             ro_enable_d, busy_d, resp_valid_d, resp_bit_d, tie_d;
  logic [CNT_W-1:0] count_a_d, count_b_d;
  logic             rise_a, rise_b;

  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (ro_a_in),
    .rise_pulse (rise_a)
  );

  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (ro_b_in),
    .rise_pulse (rise_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      ro_enable  <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_bit   <= 1'b0;
      tie        <= 1'b0;
      count_a    <= '0;
      count_b    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ro_enable  <= ro_enable_d;
      busy       <= busy_d;
      resp_valid <= resp_valid_d;
      resp_bit   <= resp_bit_d;
      tie        <= tie_d;
      count_a    <= count_a_d;
      count_b    <= count_b_d;
    end
  end

  // Next-state and next-output logic; every registered output is decided here.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    ro_enable_d  = ro_enable;
    busy_d       = busy;
    resp_valid_d = 1'b0;
    resp_bit_d   = resp_bit;
    tie_d        = tie;
    count_a_d    = count_a;
    count_b_d    = count_b;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SETTLE;
          timer_d     = '0;
          count_a_d   = '0;
          count_b_d   = '0;
          ro_enable_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (timer_q == SETTLE_LAST) begin
          state_d = ST_COUNT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_COUNT: begin
        // Saturate rather than wrap so a fast oscillator never compares low.
        if (rise_a && (count_a != CNT_MAX)) count_a_d = count_a + CNT_W'(1);
        if (rise_b && (count_b != CNT_MAX)) count_b_d = count_b + CNT_W'(1);
        if (timer_q == WINDOW_LAST) begin
          state_d     = ST_COMPARE;
          timer_d     = '0;
          ro_enable_d = 1'b0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_COMPARE: begin
        resp_bit_d   = (count_a > count_b);
        tie_d        = (count_a == count_b);
        resp_valid_d = 1'b1;
        state_d      = ST_DONE;
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ro_pair_counter.sv
// Directed bench for ro_pair_counter: timing, comparison outcomes, saturation,
// start filtering and mid-run reset.
module tb_ro_pair_counter;

  localparam int unsigned S  = 4;
  localparam int unsigned W  = 64;
  localparam int LAT     = S + W + 2;
  localparam int EN_LAST = S + W;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start3;
  logic        ro_a_in;
  logic        ro_b_in;
  logic        ro_enable, busy, resp_valid, resp_bit, tie;
  logic [15:0] count_a, count_b;
  logic        ro_enable3, busy3, resp_valid3, resp_bit3, tie3;
  logic [2:0]  count_a3, count_b3;

  int checks   = 0;
  int failures = 0;

  int   a_half = 0;
  int   b_half = 0;
  logic a_lvl  = 1'b0;
  logic b_lvl  = 1'b0;

  int n_valid, first_valid, last_valid, en_bad, busy_bad;
  int snap_a, snap_b, snap_bit, snap_tie;
  int first_valid3, snap3_a, snap3_b, snap3_bit, snap3_tie;

  ro_pair_counter #(.CNT_W(16), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_a_in(ro_a_in), .ro_b_in(ro_b_in),
    .ro_enable(ro_enable), .busy(busy), .resp_valid(resp_valid), .resp_bit(resp_bit),
    .tie(tie), .count_a(count_a), .count_b(count_b)
  );

  ro_pair_counter #(.CNT_W(3), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .ro_a_in(ro_a_in), .ro_b_in(ro_b_in),
    .ro_enable(ro_enable3), .busy(busy3), .resp_valid(resp_valid3), .resp_bit(resp_bit3),
    .tie(tie3), .count_a(count_a3), .count_b(count_b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator models: half-period in time units, or 0 to hold a level.
  always begin
    if (a_half == 0) begin ro_a_in = a_lvl; #10; end
    else begin #(a_half); ro_a_in = ~ro_a_in; end
  end
  always begin
    if (b_half == 0) begin ro_b_in = b_lvl; #10; end
    else begin #(b_half); ro_b_in = ~ro_b_in; end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start sampled at cycle 0, then observe cycles 1..last. acc2 is the cycle in
  // which a second start is expected to be accepted (0 = none).
  task automatic measure(input int last, input int rp1, input int rp2,
                         input int hold_lo, input int hold_hi, input int acc2,
                         input bit with3);
    bit exp_en, exp_busy;
    n_valid = 0; first_valid = -1; last_valid = -1; en_bad = 0; busy_bad = 0;
    first_valid3 = -1;
    @(posedge clk); #1;
    start = 1'b1; start3 = with3;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int cyc = 1; cyc <= last; cyc++) begin
      start = (cyc == rp1) || (cyc == rp2) || (cyc >= hold_lo && cyc <= hold_hi);
      exp_en   = (cyc <= EN_LAST) || (acc2 > 0 && cyc > acc2 && cyc <= acc2 + EN_LAST);
      exp_busy = (cyc <= LAT) || (acc2 > 0 && cyc > acc2 && cyc <= acc2 + LAT);
      if (ro_enable !== exp_en) en_bad++;
      if (busy !== exp_busy) busy_bad++;
      if (resp_valid === 1'b1) begin
        if (n_valid == 0) begin
          first_valid = cyc;
          snap_a = int'(count_a); snap_b = int'(count_b);
          snap_bit = int'(resp_bit); snap_tie = int'(tie);
        end
        last_valid = cyc;
        n_valid++;
      end
      if (resp_valid3 === 1'b1 && first_valid3 < 0) begin
        first_valid3 = cyc;
        snap3_a = int'(count_a3); snap3_b = int'(count_b3);
        snap3_bit = int'(resp_bit3); snap3_tie = int'(tie3);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ro_enable", int'(ro_enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_bit", int'(resp_bit), 0);
    chk("rst_tie", int'(tie), 0);
    chk("rst_count_a", int'(count_a), 0);
    chk("rst_count_b", int'(count_b), 0);
    chk("rst3_idle", int'({ro_enable3, busy3, resp_valid3, count_b3}), 0);
    rst_n = 1'b1;

    // A faster than B
    a_half = 20; b_half = 30;
    repeat (5) @(posedge clk);
    #1;
    measure(LAT + 5, 0, 0, 0, -1, 0, 1'b0);
    chk("t1_valid_cycle", first_valid, LAT);
    chk("t1_valid_pulses", n_valid, 1);
    chk("t1_enable_window", en_bad, 0);
    chk("t1_busy_window", busy_bad, 0);
    chk("t1_count_a", snap_a, 16);
    chk("t1_count_b_10_11", (snap_b == 10 || snap_b == 11) ? 1 : 0, 1);
    chk("t1_resp_bit", snap_bit, 1);
    chk("t1_tie", snap_tie, 0);
    chk("t1_hold_count_a", int'(count_a), 16);
    chk("t1_hold_resp_bit", int'(resp_bit), 1);

    // B faster than A
    a_half = 30; b_half = 20;
    repeat (5) @(posedge clk);
    #1;
    measure(LAT + 5, 0, 0, 0, -1, 0, 1'b0);
    chk("t2_valid_cycle", first_valid, LAT);
    chk("t2_count_b", snap_b, 16);
    chk("t2_count_a_10_11", (snap_a == 10 || snap_a == 11) ? 1 : 0, 1);
    chk("t2_resp_bit", snap_bit, 0);
    chk("t2_tie", snap_tie, 0);

    // Equal in-phase inputs; narrow-counter instance saturates alongside
    a_half = 0; b_half = 0; a_lvl = 1'b0; b_lvl = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    a_half = 20; b_half = 20;
    repeat (5) @(posedge clk);
    #1;
    measure(LAT + 5, 0, 0, 0, -1, 0, 1'b1);
    chk("t3_enable_window", en_bad, 0);
    chk("t3_count_a", snap_a, 16);
    chk("t3_count_b", snap_b, 16);
    chk("t3_tie", snap_tie, 1);
    chk("t3_resp_bit", snap_bit, 0);
    chk("t3w_valid_cycle", first_valid3, LAT);
    chk("t3w_count_a_sat", snap3_a, 7);
    chk("t3w_count_b_sat", snap3_b, 7);
    chk("t3w_tie", snap3_tie, 1);
    chk("t3w_resp_bit", snap3_bit, 0);

    // start re-pulsed in SETTLE and COUNT is ignored
    measure(LAT + 5, 2, 30, 0, -1, 0, 1'b0);
    chk("t4_valid_pulses", n_valid, 1);
    chk("t4_valid_cycle", first_valid, LAT);
    chk("t4_busy_window", busy_bad, 0);
    chk("t4_enable_window", en_bad, 0);

    // Reset mid-COUNT aborts the measurement
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("t5_counting_before_reset", (count_a > 0) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ro_enable", int'(ro_enable), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_count_a", int'(count_a), 0);
    chk("t5_rst_count_b", int'(count_b), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1 || busy === 1'b1) n++;
    end
    chk("t5_no_resp_after_abort", n, 0);

    // Constant-high inputs give no edges; start held across DONE runs once more
    a_half = 0; b_half = 0; a_lvl = 1'b1; b_lvl = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    measure(2 * LAT + 5, 0, 0, LAT, LAT + 2, LAT + 1, 1'b0);
    chk("t6_count_a", snap_a, 0);
    chk("t6_count_b", snap_b, 0);
    chk("t6_tie", snap_tie, 1);
    chk("t6_resp_bit", snap_bit, 0);
    chk("t6_valid_pulses", n_valid, 2);
    chk("t6_second_valid_cycle", last_valid, 2 * LAT + 1);
    chk("t6_enable_window", en_bad, 0);
    chk("t6_busy_window", busy_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_pair_counter.md
Name: ro_pair_counter

Overview:
- Downstream consumer of two ring oscillators in the serial PUF.
- On `start`, it drives the shared enable to both oscillators and lets them settle.
- It then counts rising edges of each oscillator output over a fixed window of system-clock cycles.
- It compares the two counts and emits one response bit with a valid pulse.
- The oscillator outputs are asynchronous to `clk`. They are synchronised and edge-detected in the `clk` domain, so correct counts require f_ro < f_clk/2; the oscillator configuration guarantees this.

Parameters:
- CNT_W, 16, width of each edge counter (saturating).
- WINDOW_CYCLES, 4096, number of `clk` cycles during which edges are counted.
- SETTLE_CYCLES, 16, `clk` cycles between enable rising and the start of counting.
- SYNC_STAGES, 2, flip-flop stages in each oscillator input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a measurement; sampled only in IDLE.
- ro_a_in  in  1  output of oscillator A (asynchronous).
- ro_b_in  in  1  output of oscillator B (asynchronous).
- ro_enable  out  1  registered enable to both oscillators.
- busy  out  1  high from the cycle after an accepted `start` until the cycle `resp_valid` is high, inclusive.
- resp_valid  out  1  single-cycle pulse; response fields are valid.
- resp_bit  out  1  1 when count_a > count_b, else 0.
- tie  out  1  1 when count_a == count_b.
- count_a  out  CNT_W  final edge count for A; held until the next accepted start.
- count_b  out  CNT_W  final edge count for B; held until the next accepted start.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State is IDLE.
  - ro_enable, busy, resp_valid, resp_bit, tie are 0.
  - count_a, count_b, the window/settle timer and all synchroniser flops are 0.
- States: IDLE, SETTLE, COUNT, COMPARE, DONE.
- IDLE: `start`=1 moves to SETTLE next cycle. On that transition, counters and timer clear, ro_enable and busy go 1.
- SETTLE:
  - Runs for exactly SETTLE_CYCLES cycles; no counting.
  - Synchronisers and edge detectors run so the pipeline is primed.
  - Last cycle transitions to COUNT with the timer cleared.
- COUNT:
  - Runs for exactly WINDOW_CYCLES cycles.
  - Each cycle in which the synchronised A (B) signal shows a 0→1 transition increments count_a (count_b) by 1.
  - Counters saturate at 2^CNT_W−1 and never wrap.
  - Last cycle transitions to COMPARE.
- COMPARE (1 cycle):
  - ro_enable goes 0 at entry; edges seen in this cycle are not counted.
  - resp_bit and tie are registered from an unsigned comparison of the frozen counts.
- DONE (1 cycle): resp_valid=1, busy=1; next state IDLE with busy=0.
- Latency: if `start` is sampled in IDLE at cycle 0, resp_valid is high in cycle SETTLE_CYCLES + WINDOW_CYCLES + 2, and ro_enable is high in cycles 1 .. SETTLE_CYCLES+WINDOW_CYCLES.
- `start` while busy is ignored; no queuing. `start` held high in DONE is not accepted until IDLE.
- Tie (including both counters saturated): resp_bit=0, tie=1.
- resp_bit, tie, count_a, count_b hold their values after DONE until the next accepted start clears the counts.
- Edge detection compares the last synchroniser stage with one extra registered copy. A level already high when SETTLE ends is not an edge.
- Reset mid-operation: immediate return to the reset values, including ro_enable=0. No resp_valid is produced for the aborted measurement.
- Timer width: clog2(max(WINDOW_CYCLES, SETTLE_CYCLES)+1) bits, shared by SETTLE and COUNT.

Decomposition:
- Package puf_pkg:
  - enum type ro_cnt_state_t holding IDLE/SETTLE/COUNT/COMPARE/DONE.
  - Default-value localparams for CNT_W, WINDOW_CYCLES and SETTLE_CYCLES, reused by future PUF control blocks.
- Sub-module ro_edge_sync, instantiated twice (A and B):
  - Parameter SYNC_STAGES; inputs clk, rst_n, async_in; output rise_pulse.
  - Contains the synchroniser chain and the edge-detect register.
  - Synchroniser flops carry the codebase's async-register/dont_touch attributes.

Test Plan (bench uses WINDOW_CYCLES=64, SETTLE_CYCLES=4, CNT_W=16 unless stated):
- ro_a_in period 4 clk, ro_b_in period 6 clk, both toggling continuously, pulse start → count_a=16, count_b=10 or 11, resp_bit=1, tie=0, resp_valid in cycle 70 after the start sample, exactly one cycle wide.
- Swap the periods (A=6, B=4) → resp_bit=0, tie=0, count_b=16.
- Both inputs period 4, in phase → count_a==count_b==16, tie=1, resp_bit=0. Check ro_enable high in cycles 1..68 only.
- CNT_W=3, both inputs period 4 → both counts saturate at 7 with no wrap, tie=1, resp_bit=0.
- start re-pulsed during SETTLE and during COUNT → ignored: a single resp_valid, busy continuous. Then assert rst_n=0 mid-COUNT of a second run → same-cycle ro_enable=0, busy=0, counts=0, and no resp_valid afterwards.
- Inputs held constant high through the run → counts 0, tie=1. A start held high for 3 cycles after DONE starts exactly one new measurement.
